// File: rtl/packet_framer.sv
// Transmit framer: buffers a payload stream, then hands preamble, sync,
// length, payload and checksum words one at a time to the modulator.
module packet_framer #(
  parameter int DATA_SIZE = 16,
  parameter int MAX_PAYLOAD = 16,
  parameter int PREAMBLE_WORDS = 2,
  parameter logic [DATA_SIZE-1:0] PREAMBLE_WORD = 16'hAAAA,
  parameter logic [DATA_SIZE-1:0] SYNC_WORD = 16'hA5C3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [DATA_SIZE-1:0] mod_data,
  output logic                 mod_enable,
  input  logic                 mod_done,
  output logic                 busy,
  output logic                 frame_sent,
  output logic                 trunc,
  output logic                 timeout
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int IW = $clog2(MAX_PAYLOAD + PREAMBLE_WORDS + 1);
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [2:0] {
    S_FILL, S_PRE, S_SYNC, S_LEN, S_PAY, S_CRC
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [DATA_SIZE-1:0] r_sum;
  logic [IW-1:0]        r_idx;
  logic [WW-1:0]        r_wd;
  logic                 r_act;
  logic                 r_live;
  logic                 r_sent;
  logic                 r_trunc;
  logic                 r_tout;
  logic [DATA_SIZE-1:0] r_buf [DEPTH];

  logic w_accept;
  logic w_full_next;
  logic w_done;
  logic w_wd_hit;
  logic w_pre_last;
  logic w_pay_last;

  assign w_accept    = in_valid & in_ready;
  assign w_full_next = (r_cnt == CW'(MAX_PAYLOAD - 1));
  assign w_done      = r_act & mod_done;
  assign w_wd_hit    = r_act & ~mod_done &
                       (r_wd == WW'(TIMEOUT_CYCLES - 1));
  assign w_pre_last  = (r_idx == IW'(PREAMBLE_WORDS - 1));
  assign w_pay_last  = (IW'(r_cnt) == r_idx + 1'b1);

  assign mod_enable = r_act;
  assign busy       = (r_state != S_FILL);
  assign frame_sent = r_sent;
  assign trunc      = r_trunc;
  assign timeout    = r_tout;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_next;
  end

  // Next-state: advance on word completion, watchdog aborts to FILL
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FILL: if (w_accept && (in_last || w_full_next)) w_next = S_PRE;
      S_PRE:  if (w_done && w_pre_last) w_next = S_SYNC;
      S_SYNC: if (w_done) w_next = S_LEN;
      S_LEN:  if (w_done) w_next = S_PAY;
      S_PAY:  if (w_done && w_pay_last) w_next = S_CRC;
      S_CRC:  if (w_done) w_next = S_FILL;
      default: w_next = S_FILL;
    endcase
    if (w_wd_hit) w_next = S_FILL;
  end

  // Output decode: word presented to the modulator and buffer readiness
  always_comb begin
    mod_data = '0;
    unique case (1'b1)
      (r_state == S_PRE):  mod_data = PREAMBLE_WORD;
      (r_state == S_SYNC): mod_data = SYNC_WORD;
      (r_state == S_LEN):  mod_data = DATA_SIZE'(r_cnt);
      (r_state == S_PAY):  mod_data = r_buf[r_idx[AW-1:0]];
      (r_state == S_CRC):  mod_data = DATA_SIZE'(r_cnt) + r_sum;
      default:             mod_data = '0;
    endcase
    in_ready = r_live & (r_state == S_FILL) &
               (r_cnt < CW'(MAX_PAYLOAD));
  end

  // Counters, SETUP/ACTIVE phase, watchdog and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_wd    <= '0;
      r_act   <= 1'b0;
      r_live  <= 1'b0;
      r_sent  <= 1'b0;
      r_trunc <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_sent  <= 1'b0;
      r_trunc <= 1'b0;
      r_tout  <= 1'b0;
      if (w_accept) begin
        r_cnt   <= r_cnt + 1'b1;
        r_sum   <= r_sum + in_data;
        r_trunc <= w_full_next & ~in_last;
      end
      if (r_state != S_FILL) begin
        if (!r_act) begin
          r_act <= 1'b1;
          r_wd  <= '0;
        end else if (mod_done) begin
          r_act <= 1'b0;
          r_idx <= (w_next != r_state) ? '0 : r_idx + 1'b1;
          if (r_state == S_CRC) begin
            r_sent <= 1'b1;
            r_cnt  <= '0;
            r_sum  <= '0;
          end
        end else if (w_wd_hit) begin
          r_act  <= 1'b0;
          r_tout <= 1'b1;
          r_cnt  <= '0;
          r_sum  <= '0;
          r_idx  <= '0;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
      end
    end
  end

  // Payload buffer write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_accept) begin
      r_buf[r_cnt[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: doc/packet_framer.md
# packet_framer

Builds transmit frames upstream of the BPSK signal modulator. Payload words are accepted over a valid/ready stream into an internal buffer. The block then emits the frame one word at a time: preamble, sync, length, payload, checksum. Each word is presented on `mod_data` and the modulator is started with a level `mod_enable`; its one-cycle `mod_done` pulse advances the block to the next word.

## Interface
- `DATA_SIZE`, 16: word width; must match the modulator's `DATA_SIZE`.
- `MAX_PAYLOAD`, 16: buffer depth in words (≥1).
- `PREAMBLE_WORDS`, 2: count of preamble words (≥1).
- `PREAMBLE_WORD`, 16'hAAAA: preamble value.
- `SYNC_WORD`, 16'hA5C3: sync value.
- `TIMEOUT_CYCLES`, 65535: maximum cycles `mod_enable` may stay high without `mod_done`.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in DATA_SIZE: payload word.
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: qualifies the final payload word of the frame.
- `in_ready` out 1: the buffer accepts a word.
- `mod_data` out DATA_SIZE: word currently handed to the modulator.
- `mod_enable` out 1: level-high start/hold for the modulator.
- `mod_done` in 1: one-cycle pulse from the modulator when the word is sent.
- `busy` out 1: a frame is being transmitted.
- `frame_sent` out 1: one-cycle pulse when the checksum word completes.
- `trunc` out 1: one-cycle pulse when a frame is launched because the buffer filled without `in_last`.
- `timeout` out 1: one-cycle pulse when a frame is aborted by the watchdog.

## Operation
- Reset (async assert, sync use after deassert):
  - all outputs 0, except `in_ready`=1 from the first clock after deassert;
  - state=FILL; count, checksum and watchdog all 0.
- States: FILL → PREAMBLE → SYNC → LENGTH → PAYLOAD → CHECKSUM → FILL.
- FILL:
  - `in_ready`=1 while count<MAX_PAYLOAD.
  - Each accepted word (`in_valid & in_ready`) is written to `buf[count]`, count increments, and `sum` accumulates the word.
  - The frame launches on acceptance of an `in_last` word, or on the word that makes count=MAX_PAYLOAD; the latter case also pulses `trunc`, unless that word carried `in_last`.
  - `in_last` with count=0 is impossible, since the word itself is counted.
- Per-word sub-phases:
  - SETUP (1 cycle): `mod_data` takes the new word, `mod_enable`=0.
  - ACTIVE: `mod_enable`=1 and `mod_data` is held stable until `mod_done` is sampled high.
  - The cycle after `mod_done`, the block enters the SETUP of the next word.
- Word sequence:
  - PREAMBLE_WORDS × PREAMBLE_WORD;
  - SYNC_WORD;
  - length = count, zero-extended to DATA_SIZE;
  - `buf[0..count-1]` in order;
  - checksum = (count + Σ payload) mod 2^DATA_SIZE.
- The checksum accumulator is DATA_SIZE bits wide and wraps silently.
- After the checksum word's `mod_done`:
  - `frame_sent` pulses;
  - count and sum clear;
  - state returns to FILL.
- `busy`=1 in every state except FILL.
- `mod_done` outside ACTIVE is ignored.
- `in_valid` outside FILL is ignored, because `in_ready`=0.
- Watchdog:
  - counts cycles in ACTIVE and clears on SETUP;
  - on reaching TIMEOUT_CYCLES: `mod_enable`=0, `timeout` pulses, count and sum clear, state returns to FILL;
  - buffer contents are discarded.
- Reset mid-frame aborts immediately: `mod_enable` falls asynchronously with `rst_n`, and no `frame_sent` is produced.

## Timing
- Launch latency: the last payload word is accepted at edge T; the first SETUP is at T+1 (`mod_data`=PREAMBLE_WORD, `in_ready`=0); `mod_enable` rises at T+2.
- `mod_enable` is low for exactly 1 cycle between consecutive words. The modulator's edge detector therefore sees one rising edge per word.
- A frame with N payload words contains PREAMBLE_WORDS+3+N modulator words.
- `frame_sent` is asserted in the cycle after the final `mod_done`. In that same cycle state=FILL and `in_ready`=1.
- `trunc` is asserted the cycle after the filling word is accepted.
- `timeout` is asserted the cycle after the watchdog reaches its limit.
- `mod_done` coinciding with the watchdog reaching its limit: `mod_done` wins and the word completes normally.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 → all outputs 0 during reset; after release `in_ready`=1, `busy`=0.
- Payload {16'h0001, 16'h0002, 16'h0003 with last}, modulator model returning `mod_done` 20 cycles after each `mod_enable` rise → `mod_data` sequence AAAA, AAAA, A5C3, 0003, 0001, 0002, 0003, 0009; 8 rising edges of `mod_enable`, each low gap 1 cycle; one `frame_sent` pulse.
- Checksum wrap: 2 words 16'hFFFF and 16'h0003 (last) → length 0002, checksum 16'h0004.
- Overflow: 16 words 16'h1111 with `in_last`=0 → `in_ready` drops after the 16th, `trunc` pulses once, length 0010, checksum 16'h1120; a 17th `in_valid` word is not accepted.
- Watchdog with TIMEOUT_CYCLES=100: `mod_done` withheld during SYNC → `mod_enable` falls after 100 ACTIVE cycles, `timeout` pulses, no `frame_sent`, `in_ready`=1; the next frame transmits correctly.
- `rst_n` pulsed low during PAYLOAD → `mod_enable` falls immediately; after release state=FILL and count=0; a stray `mod_done` is ignored.
